// File: rtl/instr_register_exec.sv
// Instruction register file: each load computes a signed ALU result and stores it with its operands.
// Reads return {opcode, operand_a, operand_b, result} one cycle later, gated by per-entry valid bits.
module instr_register_exec #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     write_pointer,
  input  logic [3:0]        opcode,
  input  logic [31:0]       operand_a,
  input  logic [31:0]       operand_b,
  input  logic              read_en,
  input  logic [AW-1:0]     read_pointer,
  output logic [131:0]      instruction_word,
  output logic              rd_valid,
  output logic              rd_error,
  output logic [AW:0]       count
);

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } opcode_t;

  localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

  logic [3:0]  op_mem  [DEPTH];
  logic [31:0] a_mem   [DEPTH];
  logic [31:0] b_mem   [DEPTH];
  logic [63:0] res_mem [DEPTH];
  logic        err_mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] calc_res;
  logic               calc_err;

  // Operands are widened before the ALU so MULT is exact and DIV of -2^31 by -1 cannot overflow.
  always_comb begin
    a_ext    = {{32{operand_a[31]}}, operand_a};
    b_ext    = {{32{operand_b[31]}}, operand_b};
    calc_res = '0;
    calc_err = 1'b0;
    case (opcode)
      OP_ZERO:  calc_res = '0;
      OP_PASSA: calc_res = a_ext;
      OP_PASSB: calc_res = b_ext;
      OP_ADD:   calc_res = a_ext + b_ext;
      OP_SUB:   calc_res = a_ext - b_ext;
      OP_MULT:  calc_res = a_ext * b_ext;
      OP_DIV: begin
        if (operand_b == 32'd0) calc_err = 1'b1;
        else                    calc_res = a_ext / b_ext;
      end
      OP_MOD: begin
        if (operand_b == 32'd0) calc_err = 1'b1;
        else                    calc_res = a_ext % b_ext;
      end
      default:  calc_err = 1'b1;
    endcase
  end

  // Entry payload is never cleared; the valid bits alone decide what a read may see.
  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      op_mem[write_pointer]  <= opcode;
      a_mem[write_pointer]   <= operand_a;
      b_mem[write_pointer]   <= operand_b;
      res_mem[write_pointer] <= calc_res;
      err_mem[write_pointer] <= calc_err;
    end
  end

  // Reads sample the arrays before this edge's write lands, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid            <= '0;
      count            <= '0;
      rd_valid         <= 1'b0;
      rd_error         <= 1'b0;
      instruction_word <= '0;
    end else begin
      if (load_en) begin
        valid[write_pointer] <= 1'b1;
        if (!valid[write_pointer] && count < COUNT_MAX) count <= count + 1'b1;
      end
      rd_valid <= read_en;
      if (read_en) begin
        if (valid[read_pointer]) begin
          instruction_word <= {op_mem[read_pointer], a_mem[read_pointer],
                               b_mem[read_pointer], res_mem[read_pointer]};
          rd_error         <= err_mem[read_pointer];
        end else begin
          instruction_word <= '0;
          rd_error         <= 1'b1;
        end
      end else begin
        rd_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_exec.sv
// Randomised and directed bench for instr_register_exec against an array-based reference model.
module tb_instr_register_exec;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_en;
  logic [4:0]   write_pointer;
  logic [3:0]   opcode;
  logic [31:0]  operand_a;
  logic [31:0]  operand_b;
  logic         read_en;
  logic [4:0]   read_pointer;
  logic [131:0] instruction_word;
  logic         rd_valid;
  logic         rd_error;
  logic [5:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_register_exec #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_en(read_en), .read_pointer(read_pointer),
    .instruction_word(instruction_word), .rd_valid(rd_valid),
    .rd_error(rd_error), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic        m_valid [32];
  logic [3:0]  m_op    [32];
  logic [31:0] m_a     [32];
  logic [31:0] m_b     [32];
  logic [63:0] m_res   [32];
  logic        m_err   [32];
  logic [131:0] exp_word;
  logic         exp_valid;
  logic         exp_err;

  function automatic logic [64:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, r;
    logic e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0;
    e = 1'b0;
    case (op)
      4'd0: r = 0;
      4'd1: r = sa;
      4'd2: r = sb;
      4'd3: r = sa + sb;
      4'd4: r = sa - sb;
      4'd5: r = sa * sb;
      4'd6: if (sb == 0) e = 1'b1; else r = sa / sb;
      4'd7: if (sb == 0) e = 1'b1; else r = sa % sb;
      default: e = 1'b1;
    endcase
    return {e, 64'(r)};
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  task automatic step(input logic we, input logic [4:0] wp, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic re, input logic [4:0] rp);
    logic [64:0] calc;
    load_en = we; write_pointer = wp; opcode = op; operand_a = a; operand_b = b;
    read_en = re; read_pointer = rp;
    exp_valid = re;
    if (re) begin
      if (m_valid[rp]) begin
        exp_word = {m_op[rp], m_a[rp], m_b[rp], m_res[rp]};
        exp_err  = m_err[rp];
      end else begin
        exp_word = '0;
        exp_err  = 1'b1;
      end
    end
    if (we) begin
      calc = ref_calc(op, a, b);
      m_op[wp] = op; m_a[wp] = a; m_b[wp] = b;
      m_res[wp] = calc[63:0]; m_err[wp] = calc[64]; m_valid[wp] = 1'b1;
    end
    @(posedge clk); #1;
    load_en = 1'b0; read_en = 1'b0;
  endtask

  // Holds whatever load_en/read_en the caller set, so reset priority is exercised.
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    exp_word = '0; exp_valid = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; load_en = 1'b0; read_en = 1'b0;
  endtask

  task automatic test_reset();
    load_en = 1'b1; write_pointer = 5'd3; opcode = 4'd1; operand_a = 32'd55; operand_b = 32'd0;
    read_en = 1'b1; read_pointer = 5'd3;
    do_reset();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_cmp++; if (rd_error !== 1'b0) begin n_bad++; $display("FAIL reset_rd_error got %b want 0", rd_error); end
    n_cmp++; if (instruction_word !== 132'd0) begin n_bad++; $display("FAIL reset_word got %h want 0", instruction_word); end
    n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd3);
    n_cmp++; if (rd_valid !== 1'b1 || rd_error !== 1'b1) begin n_bad++; $display("FAIL unwritten_read got v=%b e=%b want v=1 e=1", rd_valid, rd_error); end
    n_cmp++; if (instruction_word !== 132'd0) begin n_bad++; $display("FAIL unwritten_word got %h want 0", instruction_word); end
    n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL unwritten_count got %0d want 0", count); end
  endtask

  task automatic test_arith();
    logic [63:0] want [5];
    logic        want_err [5];
    want[0] = 64'hFFFF_FFFF_FFFF_FFFD; want_err[0] = 1'b0;
    want[1] = 64'h0000_0000_FFFF_FFFE; want_err[1] = 1'b0;
    want[2] = 64'hFFFF_FFFF_FFFF_FFFD; want_err[2] = 1'b0;
    want[3] = 64'hFFFF_FFFF_FFFF_FFFF; want_err[3] = 1'b0;
    want[4] = 64'd0;                   want_err[4] = 1'b1;
    step(1'b1, 5'd0, 4'd3, 32'd7, -32'sd10, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd0);
    n_cmp++; if (count !== 6'd1) begin n_bad++; $display("FAIL add_count got %0d want 1", count); end
    step(1'b1, 5'd1, 4'd5, 32'h7FFF_FFFF, 32'd2, 1'b0, 5'd0);
    step(1'b1, 5'd2, 4'd6, -32'sd7, 32'd2, 1'b0, 5'd0);
    step(1'b1, 5'd3, 4'd7, -32'sd7, 32'd2, 1'b0, 5'd0);
    step(1'b1, 5'd4, 4'd6, 32'd5, 32'd0, 1'b0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'(i));
      n_cmp++;
      if (rd_valid !== 1'b1 || instruction_word[63:0] !== want[i] || rd_error !== want_err[i]) begin
        n_bad++;
        $display("FAIL arith_%0d got v=%b res=%h e=%b want v=1 res=%h e=%b",
                 i, rd_valid, instruction_word[63:0], rd_error, want[i], want_err[i]);
      end
    end
  endtask

  task automatic test_rbw();
    step(1'b1, 5'd5, 4'd1, 32'd1, 32'd0, 1'b0, 5'd0);
    step(1'b1, 5'd5, 4'd2, 32'd0, 32'd9, 1'b1, 5'd5);
    n_cmp++; if (instruction_word[63:0] !== 64'd1) begin n_bad++; $display("FAIL rbw_old got %h want 1", instruction_word[63:0]); end
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd5);
    n_cmp++; if (instruction_word[63:0] !== 64'd9) begin n_bad++; $display("FAIL rbw_new got %h want 9", instruction_word[63:0]); end
  endtask

  task automatic test_fill_saturate();
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 4'd3, $urandom, $urandom, 1'b0, 5'd0);
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL fill_count got %0d want 32", count); end
    step(1'b1, 5'd0, 4'd4, 32'd10, 32'd3, 1'b0, 5'd0);
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL rewrite_count got %0d want 32", count); end
    step(1'b1, 5'd7, 4'd12, 32'd1, 32'd1, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd7);
    n_cmp++; if (instruction_word[63:0] !== 64'd0 || rd_error !== 1'b1) begin n_bad++; $display("FAIL illegal_op got res=%h e=%b want res=0 e=1", instruction_word[63:0], rd_error); end
    n_cmp++; if (count !== 6'd32) begin n_bad++; $display("FAIL illegal_count got %0d want 32", count); end
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    n_cmp++; if (rd_valid !== 1'b0 || instruction_word !== exp_word) begin n_bad++; $display("FAIL idle_hold got v=%b w=%h want v=0 w=%h", rd_valid, instruction_word, exp_word); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] b;
    logic [4:0] wp;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        load_en = 1'($urandom); read_en = 1'($urandom);
        write_pointer = 5'($urandom); read_pointer = 5'($urandom);
        do_reset();
        n_cmp++; if (rd_valid !== 1'b0 || instruction_word !== 132'd0 || count !== 6'd0) begin n_bad++; $display("FAIL rand_reset got v=%b w=%h c=%0d want v=0 w=0 c=0", rd_valid, instruction_word, count); end
      end else begin
        op = ($urandom_range(0, 9) > 7) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        wp = 5'($urandom);
        step(1'($urandom_range(0, 2) != 0), wp, op, $urandom, b,
             1'($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0) ? wp : 5'($urandom));
        n_cmp++;
        if (rd_valid !== exp_valid || instruction_word !== exp_word ||
            (exp_valid && rd_error !== exp_err) || count !== 6'(model_count())) begin
          n_bad++;
          $display("FAIL rand_%0d got v=%b e=%b c=%0d w=%h want v=%b e=%b c=%0d w=%h", n,
                   rd_valid, rd_error, count, instruction_word, exp_valid, exp_err,
                   model_count(), exp_word);
        end
      end
    end
  endtask

  task automatic test_read_reset();
    step(1'b1, 5'd9, 4'd1, 32'd42, 32'd0, 1'b0, 5'd0);
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd9);
    n_cmp++; if (rd_valid !== 1'b1 || instruction_word[63:0] !== 64'd42) begin n_bad++; $display("FAIL pre_reset_read got v=%b res=%h want v=1 res=2a", rd_valid, instruction_word[63:0]); end
    read_en = 1'b1; read_pointer = 5'd9; load_en = 1'b0;
    do_reset();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL read_then_reset got v=%b want 0", rd_valid); end
    step(1'b0, 5'd0, 4'd0, 32'd0, 32'd0, 1'b1, 5'd9);
    n_cmp++; if (rd_error !== 1'b1 || instruction_word !== 132'd0) begin n_bad++; $display("FAIL post_reset_read got e=%b w=%h want e=1 w=0", rd_error, instruction_word); end
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; read_en = 1'b0;
    write_pointer = '0; read_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_res[i] = '0; m_err[i] = 1'b0;
    end
    exp_word = '0; exp_valid = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_rbw();
    test_fill_saturate();
    test_read_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
